// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding, width limits and counter sizing helper.
package serial_adder_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder composed of two half adders.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .A     (A),
        .B     (B),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .A     (s0),
        .B     (cin),
        .sum   (sum),
        .carry (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, the basic cell of the serial datapath.
module half_adder (
    input  logic A,
    input  logic B,
    output logic sum,
    output logic carry
);

    assign sum   = A ^ B;
    assign carry = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first,
// framed by a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic             cff;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .A    (opa[0]),
        .B    (opb[0]),
        .cin  (cff),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 last.
    generate
        if (WIDTH == 1) begin : g_w1
            assign psum_nxt = fa_s;
        end else begin : g_wn
            assign psum_nxt = {fa_s, psum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            cff   <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        cff   <= 1'b0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    opa  <= opa >> 1;
                    opb  <= opb >> 1;
                    cff  <= fa_c;
                    psum <= psum_nxt;
                    if (cnt == LAST) begin
                        sum   <= psum_nxt;
                        carry <= fa_c;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry1;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] ps = 8'h00;
    logic       pc = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a8),
        .B     (b8),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .carry (carry1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one WIDTH=8 op from the current negedge, end at its done cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec,
                        input logic disturb);
        a8 = a;
        b8 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_sum_hold", sum, ps);
            chk("run_carry_hold", carry, pc);
            if (disturb && i == 2) begin
                start = 1'b1;
                a8 = 8'h11;
                b8 = 8'h22;
            end
            if (disturb && i == 3) begin
                start = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            @(negedge clk);
        end
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_sum", sum, es);
        chk("fin_carry", carry, ec);
        ps = es;
        pc = ec;
    endtask

    task automatic idle8();
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sum", sum, ps);
        chk("idle_carry", carry, pc);
    endtask

    task automatic run1(input logic a, input logic b,
                        input logic es, input logic ec);
        a1 = a;
        b1 = b;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        chk("w1_done_early", done1, 0);
        @(negedge clk);
        chk("w1_done", done1, 1);
        chk("w1_busy_off", busy1, 0);
        chk("w1_sum", sum1, es);
        chk("w1_carry", carry1, ec);
        @(negedge clk);
        chk("w1_done_pulse", done1, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a8 = '0;
        b8 = '0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle8();

        run8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        idle8();
        run8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        idle8();
        run8(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b1);
        run8(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
        idle8();

        a8 = 8'hFF;
        b8 = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_carry", carry, 0);
        @(negedge clk);
        rst = 1'b0;
        ps = 8'h00;
        pc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
        end
        run8(8'h03, 8'h04, 8'h07, 1'b0, 1'b0);
        idle8();

        run1(1'b0, 1'b0, 1'b0, 1'b0);
        run1(1'b0, 1'b1, 1'b1, 1'b0);
        run1(1'b1, 1'b0, 1'b1, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that consumes one-bit sum/carry results cycle by cycle.
- A single full-adder cell (built from two half_adder instances) plus a carry flip-flop processes operands LSB-first, one bit per clock.
- A start/busy/done handshake frames each operation.
- Sits directly downstream of half_adder and is the first sequential arithmetic stage in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge
- A  input  WIDTH  operand A; sampled only on the edge that accepts start
- B  input  WIDTH  operand B; sampled only on the edge that accepts start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result, registered and held until the next completion
- carry  output  1  carry-out, registered and held until the next completion

Behaviour:
- Reset (async, active-high, highest priority, effective immediately and independent of clk):
  - state = IDLE; busy = 0; done = 0; sum = 0; carry = 0.
  - Operand shift registers, partial-sum register, carry flip-flop and bit counter all cleared.
  - Reset asserted mid-RUN abandons the operation; no done pulse is produced.
- States:
  - IDLE -> RUN: on start=1. Latch A/B into shift registers; clear carry FF; counter = 0.
  - RUN: each edge, the full-adder cell takes opA[0], opB[0] and the carry FF.
    - Sum bit shifts into the MSB of the partial-sum register (shift right).
    - Operand registers shift right; carry FF updates; counter increments.
    - When counter reaches WIDTH-1 on an edge, that edge processes the final bit and moves to DONE.
    - On that same edge, sum <= completed partial sum and carry <= final carry-out.
  - DONE: done = 1 for exactly one cycle.
    - start=1 -> RUN with new operands latched (back-to-back accepted).
    - start=0 -> IDLE.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done high in the cycle following E_WIDTH (WIDTH+1 edges after acceptance). Throughput is one result per WIDTH+1 cycles when back-to-back.
- busy = 1 exactly in RUN. done = 1 exactly in DONE. busy and done are never both high. Both are decoded from the state register, no combinational path from inputs.
- start while in RUN is ignored, with no effect on operands or counter. A and B changes outside the accepting edge are ignored.
- sum/carry keep the previous result during RUN and change only on the completion edge.
- Arithmetic: {carry, sum} = A + B modulo 2^(WIDTH+1), unsigned.
- Counter width is $clog2(WIDTH) with a minimum of 1 bit; no wrap beyond WIDTH-1.
- WIDTH=1: RUN lasts one edge. Result equals the half_adder truth table (carry-in is always 0).

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
  - MAX_WIDTH=32.
- Sub-module full_adder: inputs A, B, cin; outputs sum, cout. Built from two half_adder instances plus an OR on the two carries.
- The serial_adder top holds the FSM, the shift registers and the carry FF.

Test Plan (WIDTH=8):
1. Reset, then start with A=8'h00, B=8'h00 -> busy high for 8 cycles; done pulse in the 9th cycle after acceptance; sum=8'h00, carry=0.
2. A=8'hFF, B=8'h01 -> sum=8'h00, carry=1; done high exactly one cycle; busy low in that cycle.
3. A=8'hA5, B=8'h5A -> sum=8'hFF, carry=0. While busy, pulse start with A=8'h11 and B=8'h22 and change A/B -> ignored, result unchanged. sum/carry hold the previous result (8'h00/1) until the completion edge.
4. Back-to-back: start held high through DONE with A=8'h80, B=8'h80 -> second operation begins with no IDLE cycle; result sum=8'h00, carry=1, WIDTH+1 cycles after the first done.
5. Assert rst asynchronously (mid-cycle, between edges) 4 cycles into an operation -> busy, done, sum, carry go to 0 immediately. No done pulse afterwards. A fresh start with A=8'h03, B=8'h04 yields sum=8'h07, carry=0.
6. WIDTH=1 instance, all four A/B combinations -> {carry,sum} = 00, 01, 01, 10. done arrives 2 edges after acceptance.
